// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/flush controller for load-use stalls and taken branches
//
// Purpose:
//   Sits downstream of the EX-stage condition logic. Turns a taken redirect (pcSrcE)
//   and load-use operand matches into stall/flush controls for the F, D and E pipeline
//   registers. A small FSM stretches the ID/EX bubble after a branch (BRANCH_PENALTY)
//   and holds the front end for multi-cycle load latency (LOAD_LAT).
//
// Configuration macro:
//   HAZARD_STATS_EN  build saturating 16-bit stall/flush event counters; when undefined
//                    stallCnt and flushCnt are tied to zero.
//
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-low reset
//   pcSrcE     in   1      taken branch/redirect resolved in EX
//   memToRegE  in   1      instruction in EX is a load
//   writeRegE  in   REG_W  destination register of EX instruction
//   rs1D/rs2D  in   REG_W  source registers of D instruction
//   rs1UsedD   in   1      rs1D is read by D instruction
//   rs2UsedD   in   1      rs2D is read by D instruction
//   stallF     out  1      hold PC register
//   stallD     out  1      hold IF/ID register
//   flushD     out  1      clear IF/ID register
//   flushE     out  1      clear ID/EX register (bubble)
//   busy       out  1      FSM not in RUN
//   stallCnt   out  16     cycles with stallD asserted (saturating)
//   flushCnt   out  16     cycles with flushD asserted (saturating)

module hazard_ctrl #(
  parameter int REG_W          = 4,
  parameter int BRANCH_PENALTY = 2,
  parameter int LOAD_LAT       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcSrcE,
  input  logic             memToRegE,
  input  logic [REG_W-1:0] writeRegE,
  input  logic [REG_W-1:0] rs1D,
  input  logic [REG_W-1:0] rs2D,
  input  logic             rs1UsedD,
  input  logic             rs2UsedD,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic             busy,
  output logic [15:0]      stallCnt,
  output logic [15:0]      flushCnt
);

  localparam int MAX_P = (BRANCH_PENALTY > LOAD_LAT) ? BRANCH_PENALTY : LOAD_LAT;
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam logic [CNT_W-1:0] BR_INIT = CNT_W'((BRANCH_PENALTY > 1) ? BRANCH_PENALTY - 2 : 0);
  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    LD_STALL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_mask_q, br_mask_d;

  logic lw_haz;
  logic pc_src;
  logic stall_f, stall_d, flush_d, flush_e;

  assign lw_haz = memToRegE & ((rs1UsedD & (rs1D == writeRegE)) |
                               (rs2UsedD & (rs2D == writeRegE)));

  // A redirect that is still held high after it has been acted on is the same
  // event, not a new one: ignore pcSrcE until it drops after a taken branch.
  assign pc_src = pcSrcE & ~br_mask_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;

    case (state_q)
      RUN, LD_STALL: begin
        if (pc_src) begin
          // Branch wins over any load stall, including an in-progress one.
          flush_d = 1'b1;
          flush_e = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            state_d = BR_FLUSH;
            cnt_d   = BR_INIT;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end else if (state_q == LD_STALL) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end else if (lw_haz) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = LD_STALL;
            cnt_d   = LD_INIT;
          end
        end
      end
      BR_FLUSH: begin
        flush_e = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    br_mask_d = pcSrcE & (br_mask_q | flush_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      br_mask_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      br_mask_q <= br_mask_d;
    end
  end

  // Mealy outputs are gated so nothing leaks out while reset is held low.
  assign stallF = reset & stall_f;
  assign stallD = reset & stall_d;
  assign flushD = reset & flush_d;
  assign flushE = reset & flush_e;
  assign busy   = (state_q != RUN);

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stallD && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (flushD && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;
`else
  assign stallCnt = 16'h0000;
  assign flushCnt = 16'h0000;
`endif

endmodule
